reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Shares write access to one W-bit datapath register (data in, clock, write-enable, data out) between N requesters.
- Round-robin arbitration with a four-phase req/ack handshake per requester.
- Drives the register's write-enable and data input; the arbiter is the only block that writes the register.
- Sits between the CPU's control sources (e.g. ALU result path, immediate load, debug port) and the shared register.

Parameters:
- N, 4, number of requesters (2..8).
- W, 4, data width of the shared register.

Ports:
- wa_clk  in  1  clock; all state updates on rising edge.
- wa_rst  in  1  reset, asynchronous, active-high.
- wa_req  in  N  request per requester; held high with data stable until its ack.
- wa_data  in  N*W  requester data; slice i is bits [i*W +: W].
- wa_gnt  out  N  one-hot grant; at most one bit set.
- wa_ack  out  N  one-hot write-complete acknowledge.
- wa_enb  out  1  write-enable to the shared register.
- wa_wdata  out  W  data to the shared register input.
- wa_busy  out  1  high whenever the FSM is not IDLE.
- wa_owner  out  clog2(N)  index of the current/last granted requester.

Behaviour:
- Reset (async assert): state=IDLE, wa_gnt=0, wa_ack=0, wa_enb=0, wa_wdata=0, wa_busy=0, wa_owner=0, rr pointer=0. Outputs clear immediately on assertion, not at the next edge.
- All outputs are registered; none is combinational from wa_req.
- FSM states are IDLE, GRANT, WRITE, DONE.
- IDLE:
  - If any wa_req bit is set, pick the first set bit searching from ptr upward, wrapping modulo N.
  - Next state GRANT; wa_owner <= winner; wa_wdata <= winner's data slice.
- GRANT:
  - wa_gnt[owner]=1, wa_busy=1.
  - If wa_req[owner] is still 1, go to WRITE.
  - If wa_req[owner]=0 (withdrawn), abort: go to IDLE, no write, ptr unchanged, no ack.
- WRITE:
  - wa_enb=1 for exactly one cycle; gnt is held.
  - wa_wdata is held from the IDLE capture; later changes on wa_data are ignored.
  - Always go to DONE. Withdrawing req here does not abort the write.
- DONE:
  - wa_enb=0; wa_ack[owner]=1 and wa_gnt[owner]=1 held while wa_req[owner]=1.
  - When wa_req[owner]=0: go to IDLE, clear ack/gnt, ptr <= (owner+1) mod N.
- Latency:
  - req seen in IDLE at edge k: gnt visible after edge k, enb high after edge k+1.
  - Register loads at edge k+2; ack visible after edge k+2.
  - Minimum 4 cycles per transaction including the return to IDLE.
- wa_wdata holds its value outside transactions; it changes only on an IDLE capture.
- Simultaneous requests: exactly one is granted. The others wait; their req must stay high to be considered.
- Fairness: with all N requesting continuously, grants cycle ptr, ptr+1, …; each requester waits at most N-1 transactions.
- Wrap: owner N-1 completing sets ptr=0.
- A new request arriving while busy is not sampled until IDLE.
- Reset mid-WRITE: wa_enb drops asynchronously, so the register write is not guaranteed. The requester sees no ack and must re-request after reset.
- wa_gnt and wa_ack never have more than one bit set.
- wa_ack is never high in the same cycle as wa_enb.

Decomposition:
- Package reg_arb_pkg holds:
  - state enum (IDLE, GRANT, WRITE, DONE), 2-bit encoding.
  - localparam defaults N_DEF=4, W_DEF=4.
  - function rr_pick(req, ptr) returning the index and a valid flag.
- One sub-module is natural: rr_priority_picker (combinational round-robin search, parameterised N). It is instantiated once and reused by later arbiters.
- The FSM and output registers stay in reg_write_arbiter.
- The bench instantiates the arbiter plus the existing 4-bit register, connecting wa_enb to the register's enable and wa_wdata to its data input.

Test Plan:
- Reset then single request:
  - Stimulus: wa_rst high 2 cycles, low; req[1]=1, data[1]=4'b1010.
  - Required: gnt=0010 next cycle; enb high one cycle after that; register out=1010 after that edge; ack[1]=1.
  - Then drop req[1]: ack=0, busy=0 next cycle, ptr=2.
- Contention:
  - Stimulus: req=1111, data 0011/0101/0110/1001 (for requesters 0..3), ptr=0; each requester drops req one cycle after its ack.
  - Required: grant order 0,1,2,3; register outputs 0011,0101,0110,1001 in sequence; the next round starts at 0.
- Withdraw in GRANT:
  - Stimulus: req[2] pulsed high for one cycle only.
  - Required: gnt[2] for one cycle, enb never high, register holds its previous value, no ack, ptr unchanged.
- Data change after capture:
  - Stimulus: req[0] with data 1100; data[0] changes to 1111 during GRANT/WRITE.
  - Required: register loads 1100.
- Reset mid-operation:
  - Stimulus: assert wa_rst during WRITE.
  - Required: enb, gnt, ack, busy go to 0 before the next edge; ptr=0; FSM restarts in IDLE after deassert.
- Hold/ack protocol:
  - Stimulus: keep req[3] high for 5 cycles after ack.
  - Required: ack[3] held 5+ cycles, enb pulses once only, no second write.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and round-robin search for register write arbiters
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int N_DEF = 4;
  localparam int W_DEF = 4;
  localparam int N_MAX = 8;
  localparam int IW    = 3;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping modulo n (n <= N_MAX).
  function automatic rr_pick_t rr_pick(input logic [N_MAX-1:0] req,
                                       input logic [IW-1:0]    ptr,
                                       input int               n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 0; k < N_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !r.valid && req[idx[IW-1:0]]) begin
        r.valid = 1'b1;
        r.idx   = idx[IW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/data_reg.sv
// rtl/data_reg.sv - plain W-bit datapath register with write enable
module data_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (we) q <= d;
  end

endmodule

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin request picker
module rr_priority_picker
  import reg_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  logic [N_MAX-1:0] req_ext;
  rr_pick_t         pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, IW'(ptr), N);
    valid          = pick.valid && ({1'b0, pick.idx} < 4'(N));
    idx            = PW'(pick.idx);
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin req/ack arbiter owning the shared register write port
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  localparam int PW = $clog2(N)
) (
  input  logic           wa_clk,
  input  logic           wa_rst,
  input  logic [N-1:0]   wa_req,
  input  logic [N*W-1:0] wa_data,
  output logic [N-1:0]   wa_gnt,
  output logic [N-1:0]   wa_ack,
  output logic           wa_enb,
  output logic [W-1:0]   wa_wdata,
  output logic           wa_busy,
  output logic [PW-1:0]  wa_owner
);

  arb_state_t    state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] owner_nxt;
  logic [W-1:0]  wdata_nxt;
  logic [N-1:0]  gnt_nxt, ack_nxt;
  logic          enb_nxt;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          owner_req;
  logic [N-1:0]  owner_onehot;

  rr_priority_picker #(.N(N), .PW(PW)) u_picker (
    .req   (wa_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req    = wa_req[wa_owner];
  assign owner_onehot = N'(1) << wa_owner;

  always_ff @(posedge wa_clk or posedge wa_rst) begin
    if (wa_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      wa_owner <= '0;
      wa_wdata <= '0;
      wa_gnt   <= '0;
      wa_ack   <= '0;
      wa_enb   <= 1'b0;
      wa_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      wa_owner <= owner_nxt;
      wa_wdata <= wdata_nxt;
      wa_gnt   <= gnt_nxt;
      wa_ack   <= ack_nxt;
      wa_enb   <= enb_nxt;
      wa_busy  <= (state_nxt != IDLE);
    end
  end

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = wa_owner;
    wdata_nxt = wa_wdata;
    gnt_nxt   = wa_gnt;
    ack_nxt   = wa_ack;
    enb_nxt   = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        ack_nxt = '0;
        if (pick_valid) begin
          state_nxt = GRANT;
          owner_nxt = pick_idx;
          wdata_nxt = wa_data[int'(pick_idx)*W +: W];
          gnt_nxt   = N'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (owner_req) begin
          state_nxt = WRITE;
          enb_nxt   = 1'b1;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      WRITE: begin
        state_nxt = DONE;
        ack_nxt   = owner_onehot;
      end
      DONE: begin
        if (!owner_req) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ack_nxt   = '0;
          ptr_nxt   = (wa_owner == PW'(N-1)) ? '0 : wa_owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
